// File: rtl/of_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : of_stage_pipe
// Brief    : Operand-fetch stage with register file, writeback bypass,
//            immediate extension, branch target and OF/EX pipeline register.
//            Optional macro OF_ZERO_REG_EN makes register 0 a hard zero.
// Revision : 1.0
// ============================================================================
module of_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    parameter int CW_W   = 22,
    parameter int RA_IDX = 15,
    localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [CW_W-1:0]   ctrl_in,
    input  logic              is_ret,
    input  logic              is_st,
    input  logic              is_imm,
    input  logic              is_call,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [31:0]       ex_instr,
    output logic [CW_W-1:0]   ex_ctrl,
    output logic [DATA_W-1:0] ex_bt,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_pc
);

`ifdef OF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];

    logic [AW+3:0]     a1_ext, a2_ext;
    logic [AW-1:0]     a1, a2;
    logic [DATA_W-1:0] rd1, rd2;
    logic [DATA_W-1:0] imm_ext, off, bt;

    logic              ex_valid_q, ex_valid_d;
    logic [31:0]       ex_instr_q, ex_instr_d;
    logic [CW_W-1:0]   ex_ctrl_q,  ex_ctrl_d;
    logic [DATA_W-1:0] ex_bt_q,    ex_bt_d;
    logic [DATA_W-1:0] ex_a_q,     ex_a_d;
    logic [DATA_W-1:0] ex_b_q,     ex_b_d;
    logic [DATA_W-1:0] ex_op2_q,   ex_op2_d;
    logic [DATA_W-1:0] ex_pc_q,    ex_pc_d;

    // 4-bit instruction fields are truncated or zero-extended to AW bits
    always_comb begin
        a1_ext = {{AW{1'b0}}, instr[21:18]};
        a2_ext = {{AW{1'b0}}, is_st ? instr[25:22] : instr[17:14]};
        a1     = is_ret ? AW'(RA_IDX) : a1_ext[AW-1:0];
        a2     = a2_ext[AW-1:0];
    end

    always_comb begin
        rd1 = (int'(a1) < NREGS) ? rf_q[a1] : '0;
        if (ZERO_REG && a1 == '0)
            rd1 = '0;
        else if (wb_en && wb_addr == a1)
            rd1 = wb_data;

        rd2 = (int'(a2) < NREGS) ? rf_q[a2] : '0;
        if (ZERO_REG && a2 == '0)
            rd2 = '0;
        else if (wb_en && wb_addr == a2)
            rd2 = wb_data;
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en && int'(wb_addr) < NREGS && !(ZERO_REG && wb_addr == '0))
            rf_d[wb_addr] = wb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= '0;
        end else begin
            rf_q <= rf_d;
        end
    end

    always_comb begin
        case (instr[17:16])
            2'b01:   imm_ext = DATA_W'(instr[15:0]);
            2'b10:   imm_ext = DATA_W'({instr[15:0], 16'h0000});
            default: imm_ext = {{(DATA_W-16){instr[15]}}, instr[15:0]};
        endcase
        off = {{(DATA_W-27){instr[26]}}, instr[26:0]};
        bt  = is_call ? off : pc_in + off;
    end

    // Flush outranks stall; a stall freezes every field
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_instr_d = ex_instr_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_bt_d    = ex_bt_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_op2_d   = ex_op2_q;
        ex_pc_d    = ex_pc_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_instr_d = '0;
            ex_ctrl_d  = '0;
            ex_bt_d    = '0;
            ex_a_d     = '0;
            ex_b_d     = '0;
            ex_op2_d   = '0;
            ex_pc_d    = '0;
        end else if (!stall) begin
            ex_valid_d = in_valid;
            ex_instr_d = instr;
            ex_ctrl_d  = in_valid ? ctrl_in : '0;
            ex_bt_d    = bt;
            ex_a_d     = rd1;
            ex_b_d     = is_imm ? imm_ext : rd2;
            ex_op2_d   = rd2;
            ex_pc_d    = pc_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_instr_q <= '0;
            ex_ctrl_q  <= '0;
            ex_bt_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_op2_q   <= '0;
            ex_pc_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_instr_q <= ex_instr_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_bt_q    <= ex_bt_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_op2_q   <= ex_op2_d;
            ex_pc_q    <= ex_pc_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_instr = ex_instr_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign ex_bt    = ex_bt_q;
    assign ex_a     = ex_a_q;
    assign ex_b     = ex_b_q;
    assign ex_op2   = ex_op2_q;
    assign ex_pc    = ex_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_of_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_of_stage_pipe
// Brief    : Directed plus randomized bench for of_stage_pipe against a
//            behavioural model of the register file and OF/EX register.
// Revision : 1.0
// ============================================================================
module tb_of_stage_pipe;
    localparam int DATA_W = 32;
    localparam int NREGS  = 16;
    localparam int CW_W   = 22;
    localparam int RA_IDX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, is_ret, is_st, is_imm, is_call, stall, flush, wb_en;
    logic [31:0] instr, pc_in, wb_data;
    logic [21:0] ctrl_in;
    logic [3:0]  wb_addr;
    logic        ex_valid;
    logic [31:0] ex_instr, ex_bt, ex_a, ex_b, ex_op2, ex_pc;
    logic [21:0] ex_ctrl;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mrf [16];
    logic        e_valid;
    logic [31:0] e_instr, e_bt, e_a, e_b, e_op2, e_pc;
    logic [21:0] e_ctrl;

`ifdef OF_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    of_stage_pipe #(.DATA_W(DATA_W), .NREGS(NREGS), .CW_W(CW_W), .RA_IDX(RA_IDX)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .pc_in(pc_in),
        .ctrl_in(ctrl_in), .is_ret(is_ret), .is_st(is_st), .is_imm(is_imm),
        .is_call(is_call), .stall(stall), .flush(flush), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .ex_valid(ex_valid),
        .ex_instr(ex_instr), .ex_ctrl(ex_ctrl), .ex_bt(ex_bt), .ex_a(ex_a),
        .ex_b(ex_b), .ex_op2(ex_op2), .ex_pc(ex_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(ex_valid), 32'(e_valid));
        check({tag, ".instr"}, ex_instr, e_instr);
        check({tag, ".ctrl"},  32'(ex_ctrl), 32'(e_ctrl));
        check({tag, ".bt"},    ex_bt,  e_bt);
        check({tag, ".a"},     ex_a,   e_a);
        check({tag, ".b"},     ex_b,   e_b);
        check({tag, ".op2"},   ex_op2, e_op2);
        check({tag, ".pc"},    ex_pc,  e_pc);
    endtask

    function automatic logic [31:0] mread(input logic [3:0] a);
        if (ZR && a == 4'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mrf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mrf[i] = 32'd0;
        {e_valid, e_instr, e_ctrl, e_bt, e_a, e_b, e_op2, e_pc} = '0;
    endtask

    task automatic clear_inputs();
        {in_valid, is_ret, is_st, is_imm, is_call, stall, flush, wb_en} = '0;
        instr = '0; pc_in = '0; wb_data = '0; ctrl_in = '0; wb_addr = '0;
    endtask

    // One clock: predict the OF/EX contents, advance, compare
    task automatic step(input string tag);
        logic [31:0] op2, imm;
        if (flush) begin
            {e_valid, e_instr, e_ctrl, e_bt, e_a, e_b, e_op2, e_pc} = '0;
        end else if (!stall) begin
            case (instr[17:16])
                2'b01:   imm = {16'd0, instr[15:0]};
                2'b10:   imm = {instr[15:0], 16'd0};
                default: imm = 32'($signed(instr[15:0]));
            endcase
            op2     = mread(is_st ? instr[25:22] : instr[17:14]);
            e_valid = in_valid;
            e_instr = instr;
            e_ctrl  = in_valid ? ctrl_in : 22'd0;
            e_pc    = pc_in;
            e_a     = mread(is_ret ? 4'(RA_IDX) : instr[21:18]);
            e_op2   = op2;
            e_b     = is_imm ? imm : op2;
            e_bt    = is_call ? 32'($signed(instr[26:0]))
                              : pc_in + 32'($signed(instr[26:0]));
        end
        if (wb_en && !(ZR && wb_addr == 4'd0)) mrf[wb_addr] = wb_data;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] held;
        clear_inputs();
        model_reset();
        rst = 1'b1;
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // write r3, then read it as rs1
        wb_en = 1; wb_addr = 4'd3; wb_data = 32'h1234;
        step("wb_r3");
        clear_inputs();
        in_valid = 1; instr = 32'd3 << 18; ctrl_in = 22'h155;
        step("read_r3");
        check("read_r3_direct", ex_a, 32'h1234);
        check("read_r3_valid", 32'(ex_valid), 32'd1);

        // same-cycle bypass on rs2
        clear_inputs();
        in_valid = 1; instr = 32'd5 << 14; wb_en = 1; wb_addr = 4'd5; wb_data = 32'hCAFE;
        step("bypass");
        check("bypass_b", ex_b, 32'hCAFE);
        check("bypass_op2", ex_op2, 32'hCAFE);

        // immediate modifiers
        clear_inputs();
        in_valid = 1; is_imm = 1;
        instr = 32'h0000_8001;            step("imm00"); check("imm00_b", ex_b, 32'hFFFF_8001);
        instr = 32'h0001_8001;            step("imm01"); check("imm01_b", ex_b, 32'h0000_8001);
        instr = 32'h0002_8001;            step("imm10"); check("imm10_b", ex_b, 32'h8001_0000);
        instr = 32'h0003_8001;            step("imm11"); check("imm11_b", ex_b, 32'hFFFF_8001);

        // branch target, relative and absolute
        clear_inputs();
        in_valid = 1; pc_in = 32'h100; instr = 32'h07FF_FFF0;
        step("br_rel");  check("br_rel_bt", ex_bt, 32'h0000_00F0);
        is_call = 1;
        step("br_call"); check("br_call_bt", ex_bt, 32'hFFFF_FFF0);

        // return and store address selection
        clear_inputs();
        wb_en = 1; wb_addr = 4'd15; wb_data = 32'hA5A5_0F0F; step("wb_r15");
        wb_addr = 4'd9; wb_data = 32'h0BAD_F00D;          step("wb_r9");
        clear_inputs();
        in_valid = 1; is_ret = 1; is_st = 1; instr = 32'd9 << 22;
        step("ret_st");
        check("ret_a", ex_a, 32'hA5A5_0F0F);
        check("st_op2", ex_op2, 32'h0BAD_F00D);

        // stall holds for two cycles, then stall+flush squashes
        clear_inputs();
        in_valid = 1; instr = 32'h0123_4567; ctrl_in = 22'h3ABCD; pc_in = 32'h400;
        step("capture_x");
        held = ex_instr;
        stall = 1; instr = 32'h7654_3210; ctrl_in = 22'h1; pc_in = 32'h999;
        step("stall1");
        step("stall2");
        check("stall_instr", ex_instr, 32'h0123_4567);
        check("stall_pc", ex_pc, 32'h400);
        flush = 1;
        step("stall_flush");
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_ctrl", 32'(ex_ctrl), 32'd0);

        // bubble: in_valid low zeroes ctrl
        clear_inputs();
        instr = 32'h1111_1111; ctrl_in = 22'h2AAAA;
        step("bubble");

        // async reset in the middle of a stall
        clear_inputs();
        wb_en = 1; wb_addr = 4'd7; wb_data = 32'hDEAD_BEEF; step("wb_r7");
        clear_inputs();
        in_valid = 1; instr = 32'd7 << 18; ctrl_in = 22'h77; step("read_r7_pre");
        check("r7_pre", ex_a, 32'hDEAD_BEEF);
        stall = 1; step("stall_pre_rst");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        stall = 0;
        step("read_r7_post");
        check("r7_post", ex_a, 32'd0);

`ifdef OF_ZERO_REG_EN
        clear_inputs();
        wb_en = 1; wb_addr = 4'd0; wb_data = 32'h55; in_valid = 1; instr = 32'd0;
        step("r0_bypass");
        check("r0_bypass_a", ex_a, 32'd0);
        clear_inputs();
        in_valid = 1; instr = 32'd0;
        step("r0_read");
        check("r0_read_a", ex_a, 32'd0);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_valid = 1'($urandom);
            instr    = $urandom;
            pc_in    = $urandom;
            ctrl_in  = 22'($urandom);
            is_ret   = ($urandom_range(0, 7) == 0);
            is_st    = ($urandom_range(0, 3) == 0);
            is_imm   = 1'($urandom);
            is_call  = ($urandom_range(0, 3) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            wb_en    = 1'($urandom);
            wb_addr  = 4'($urandom);
            wb_data  = $urandom;
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
